rgb_line_ring_buffer: RTL and testbench
=======================================

RGB_LINE_RING_BUFFER -- requirements
Module: rgb_line_ring_buffer

Interface
REQ-001 SHALL have parameter DATA_W, default 16, pixel width in bits.
REQ-002 SHALL have parameter LINE_LEN, default 1280, pixels per line (>=2).
REQ-003 SHALL have parameter NUM_LINES, default 4, line slots in the ring (>=2).
REQ-004 SHALL have port i_clk  input  1  the single clock; all logic on its rising edge.
REQ-005 SHALL have port i_rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port i_sof  input  1  start-of-frame pulse; abandons any partial write line.
REQ-007 SHALL have port i_wr_en  input  1  camera pixel strobe.
REQ-008 SHALL have port i_wr_data  input  DATA_W  camera pixel.
REQ-009 SHALL have port i_rd_start  input  1  request to stream out the oldest committed line.
REQ-010 SHALL have port o_rd_data  output  DATA_W  pixel read out.
REQ-011 SHALL have port o_rd_valid  output  1  o_rd_data is valid this cycle.
REQ-012 SHALL have port o_rd_last  output  1  marks the final pixel of a line, coincident with o_rd_valid.
REQ-013 SHALL have port o_rd_busy  output  1  read state machine is in READ.
REQ-014 SHALL have port o_lines_avail  output  clog2(NUM_LINES+1)  count of committed, unread lines.
REQ-015 SHALL have port o_overflow  output  1  sticky flag; a line was dropped because the ring was full.

Function
REQ-016 SHALL store pixels in an inferred dual-port RAM of NUM_LINES*LINE_LEN words with a 1-cycle registered read.
REQ-017 SHALL keep a write column counter (0..LINE_LEN-1) and a write slot pointer (0..NUM_LINES-1).
REQ-018 SHALL write i_wr_data to (wr_slot, wr_col) on each i_wr_en unless the current line is marked dropped.
REQ-019 SHALL increment wr_col on each i_wr_en and wrap it from LINE_LEN-1 to 0.
REQ-020 SHALL commit a line on the i_wr_en at wr_col==LINE_LEN-1 if it was not dropped: wr_slot advances (modulo NUM_LINES) and the count increments.
REQ-021 SHALL latch the drop flag on the i_wr_en at wr_col==0: dropped = (count==NUM_LINES) at that cycle.
REQ-022 SHALL set o_overflow when a line is marked dropped, and SHALL hold it until reset.
REQ-023 SHALL count a dropped line's pixels for column alignment but SHALL neither write nor commit them.
REQ-024 SHALL, on i_sof, force wr_col to 0 and discard the partial line without committing it; committed lines are unaffected.
REQ-025 SHALL, on i_sof and i_wr_en in the same cycle, treat that pixel as column 0 of the new line.
REQ-026 SHALL implement a read FSM with states IDLE and READ.
REQ-027 SHALL move from IDLE to READ on i_rd_start when count>0, loading rd_col=0.
REQ-028 SHALL ignore i_rd_start when count==0 or while in READ.
REQ-029 SHALL, in READ, issue one read address (rd_slot, rd_col) per cycle with rd_col incrementing.
REQ-030 SHALL assert o_rd_valid exactly one cycle after each address issue, giving LINE_LEN consecutive valid cycles per line.
REQ-031 SHALL, on issuing rd_col==LINE_LEN-1, return to IDLE, advance rd_slot modulo NUM_LINES, and decrement the count.
REQ-032 SHALL assert o_rd_last together with the final o_rd_valid; o_rd_busy SHALL equal (state==READ).
REQ-033 SHALL leave the count unchanged when a commit and a release occur in the same cycle.
REQ-034 SHALL never overwrite the slot being read; this is guaranteed by the drop rule of REQ-021.
REQ-035 SHALL hold o_rd_data at its last value when o_rd_valid is low.

Reset
REQ-036 SHALL, on i_rst, clear wr_col, wr_slot, rd_col, rd_slot, count, the drop flag and o_overflow, and enter IDLE.
REQ-037 SHALL drive o_rd_valid=0, o_rd_last=0, o_rd_busy=0, o_lines_avail=0, o_overflow=0 and o_rd_data=0 in the cycle after reset.
REQ-038 SHALL let i_rst override all other inputs, including a reset mid-READ, which aborts without further o_rd_valid; RAM contents are not cleared.

Verification (LINE_LEN=8, NUM_LINES=2, DATA_W=16)
REQ-039 SHALL test the basic line: write 8 pixels 0x0000..0x0007, then pulse i_rd_start -> o_lines_avail 1 then 0; o_rd_valid for 8 cycles starting 2 cycles after start with data 0..7; o_rd_last on 0x0007.
REQ-040 SHALL test overflow: write 3 full lines (0x1xx, 0x2xx, 0x3xx) with no reads -> o_lines_avail=2, o_overflow=1; two reads return lines 1 and 2 only.
REQ-041 SHALL test i_sof mid-line: write 5 pixels, then i_sof together with pixel 0xA0, then 7 more pixels -> one line committed, read data 0xA0..0xA7.
REQ-042 SHALL test simultaneous commit and release: reading line 1 while the last pixel of line 2 is written on the final read-issue cycle -> o_lines_avail stays 1.
REQ-043 SHALL test ignored requests: i_rd_start with count 0, and again during READ -> no state change and no extra valid cycles.
REQ-044 SHALL test reset mid-READ: assert i_rst on the 4th valid cycle -> all outputs 0 the next cycle; o_lines_avail=0.

Source files
------------

// File: rtl/rgb_line_ring_buffer.sv
// Ring of NUM_LINES camera line slots: a writer commits full lines, a reader
// streams the oldest committed line out with a one-cycle registered RAM read.
module rgb_line_ring_buffer #(
    parameter int DATA_W    = 16,
    parameter int LINE_LEN  = 1280,
    parameter int NUM_LINES = 4
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic                             i_sof,
    input  logic                             i_wr_en,
    input  logic [DATA_W-1:0]                i_wr_data,
    input  logic                             i_rd_start,
    output logic [DATA_W-1:0]                o_rd_data,
    output logic                             o_rd_valid,
    output logic                             o_rd_last,
    output logic                             o_rd_busy,
    output logic [$clog2(NUM_LINES+1)-1:0]   o_lines_avail,
    output logic                             o_overflow
);

    localparam int DEPTH  = NUM_LINES * LINE_LEN;
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int COL_W  = $clog2(LINE_LEN);
    localparam int SLOT_W = $clog2(NUM_LINES);
    localparam int CNT_W  = $clog2(NUM_LINES + 1);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(LINE_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NUM_LINES);

    typedef enum logic {IDLE, READ} state_t;

    function automatic logic [SLOT_W-1:0] next_slot(input logic [SLOT_W-1:0] s);
        return (s == SLOT_W'(NUM_LINES - 1)) ? '0 : s + SLOT_W'(1);
    endfunction

    function automatic logic [ADDR_W-1:0] addr_of(input logic [SLOT_W-1:0] s,
                                                   input logic [COL_W-1:0]  c);
        return ADDR_W'(s) * ADDR_W'(LINE_LEN) + ADDR_W'(c);
    endfunction

    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state_q, state_d;
    logic [COL_W-1:0]  wr_col_q, wr_col_d, wr_col_eff;
    logic [SLOT_W-1:0] wr_slot_q, wr_slot_d;
    logic [COL_W-1:0]  rd_col_q, rd_col_d;
    logic [SLOT_W-1:0] rd_slot_q, rd_slot_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              drop_q, drop_d, drop_eff;
    logic              overflow_q, overflow_d;
    logic              rd_valid_q, rd_valid_d;
    logic              rd_last_q, rd_last_d;
    logic [DATA_W-1:0] rd_data_q;
    logic              ram_we, rd_issue, commit, rel;

    always_comb begin
        state_d    = state_q;
        wr_col_d   = wr_col_q;
        wr_slot_d  = wr_slot_q;
        rd_col_d   = rd_col_q;
        rd_slot_d  = rd_slot_q;
        count_d    = count_q;
        drop_d     = drop_q;
        overflow_d = overflow_q;
        rd_valid_d = 1'b0;
        rd_last_d  = 1'b0;
        ram_we     = 1'b0;
        rd_issue   = 1'b0;
        commit     = 1'b0;
        rel        = 1'b0;

        // A start-of-frame pixel is column 0 of a fresh line; the drop
        // decision is made against the count as it stands at column 0.
        wr_col_eff = i_sof ? '0 : wr_col_q;
        drop_eff   = (wr_col_eff == '0) ? (count_q == CNT_FULL) : drop_q;

        if (i_sof) begin
            wr_col_d = '0;
        end
        if (i_wr_en) begin
            drop_d   = drop_eff;
            ram_we   = !drop_eff;
            wr_col_d = (wr_col_eff == COL_LAST) ? '0 : wr_col_eff + COL_W'(1);
            if (drop_eff) begin
                overflow_d = 1'b1;
            end
            if (wr_col_eff == COL_LAST && !drop_eff) begin
                commit    = 1'b1;
                wr_slot_d = next_slot(wr_slot_q);
            end
        end

        case (state_q)
            IDLE: begin
                if (i_rd_start && count_q != '0) begin
                    state_d  = READ;
                    rd_col_d = '0;
                end
            end
            READ: begin
                rd_issue   = 1'b1;
                rd_valid_d = 1'b1;
                if (rd_col_q == COL_LAST) begin
                    rd_last_d = 1'b1;
                    state_d   = IDLE;
                    rd_slot_d = next_slot(rd_slot_q);
                    rel       = 1'b1;
                end else begin
                    rd_col_d = rd_col_q + COL_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        case ({commit, rel})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            wr_col_q   <= '0;
            wr_slot_q  <= '0;
            rd_col_q   <= '0;
            rd_slot_q  <= '0;
            count_q    <= '0;
            drop_q     <= 1'b0;
            overflow_q <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_col_q   <= wr_col_d;
            wr_slot_q  <= wr_slot_d;
            rd_col_q   <= rd_col_d;
            rd_slot_q  <= rd_slot_d;
            count_q    <= count_d;
            drop_q     <= drop_d;
            overflow_q <= overflow_d;
            rd_valid_q <= rd_valid_d;
            rd_last_q  <= rd_last_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (ram_we && !i_rst) begin
            mem[addr_of(wr_slot_q, wr_col_eff)] <= i_wr_data;
        end
    end

    // Output register only loads on an issued read, so data holds between lines.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rd_data_q <= '0;
        end else if (rd_issue) begin
            rd_data_q <= mem[addr_of(rd_slot_q, rd_col_q)];
        end
    end

    assign o_rd_data     = rd_data_q;
    assign o_rd_valid    = rd_valid_q;
    assign o_rd_last     = rd_last_q;
    assign o_rd_busy     = (state_q == READ);
    assign o_lines_avail = count_q;
    assign o_overflow    = overflow_q;

endmodule

// File: tb/tb_rgb_line_ring_buffer.sv
// Directed bench for rgb_line_ring_buffer (8-pixel lines, 2 slots); a monitor
// pops expected read pixels from a scoreboard queue on every valid output.
module tb_rgb_line_ring_buffer;

    localparam int DW = 16;
    localparam int LL = 8;
    localparam int NL = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          sof = 1'b0;
    logic          wr_en = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          rd_start = 1'b0;
    logic [DW-1:0] rd_data;
    logic          rd_valid, rd_last, rd_busy, overflow;
    logic [1:0]    lines_avail;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          l;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   tests = 0;
    int   fails = 0;

    rgb_line_ring_buffer #(.DATA_W(DW), .LINE_LEN(LL), .NUM_LINES(NL)) dut (
        .i_clk(clk), .i_rst(rst), .i_sof(sof), .i_wr_en(wr_en), .i_wr_data(wr_data),
        .i_rd_start(rd_start), .o_rd_data(rd_data), .o_rd_valid(rd_valid),
        .o_rd_last(rd_last), .o_rd_busy(rd_busy), .o_lines_avail(lines_avail),
        .o_overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rd_valid) begin
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL rd_unexpected: got valid data 0x%0h, expected no valid", rd_data);
            end else begin
                mon_e = q.pop_front();
                check("rd_data", {16'h0, rd_data}, {16'h0, mon_e.d});
                check("rd_last", {31'h0, rd_last}, {31'h0, mon_e.l});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_pix(input logic [DW-1:0] d, input logic s);
        wr_en = 1'b1; wr_data = d; sof = s;
        tick();
        wr_en = 1'b0; sof = 1'b0;
    endtask

    task automatic wr_line(input logic [DW-1:0] base);
        for (int i = 0; i < LL; i++) wr_pix(base + DW'(i), 1'b0);
    endtask

    task automatic push_line(input logic [DW-1:0] base);
        for (int i = 0; i < LL; i++) q.push_back({base + DW'(i), i == LL - 1});
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            if (!rd_busy && !rd_valid) done = 1'b1;
            else tick();
        end
        check("idle_timeout", {31'h0, done}, 32'h1);
    endtask

    task automatic pulse_start();
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
    endtask

    task automatic read_line(input logic [DW-1:0] base);
        push_line(base);
        pulse_start();
        wait_idle();
    endtask

    initial begin
        tick(); tick();
        rst = 1'b0;
        check("rst_valid", {31'h0, rd_valid}, 0);
        check("rst_last", {31'h0, rd_last}, 0);
        check("rst_busy", {31'h0, rd_busy}, 0);
        check("rst_avail", {30'h0, lines_avail}, 0);
        check("rst_ovf", {31'h0, overflow}, 0);
        check("rst_data", {16'h0, rd_data}, 0);

        // basic line with exact start-to-valid latency
        wr_line(16'h0000);
        check("basic_avail1", {30'h0, lines_avail}, 1);
        push_line(16'h0000);
        pulse_start();
        check("basic_busy", {31'h0, rd_busy}, 1);
        check("basic_nolat", {31'h0, rd_valid}, 0);
        tick();
        check("basic_lat2", {31'h0, rd_valid}, 1);
        wait_idle();
        check("basic_avail0", {30'h0, lines_avail}, 0);

        // overflow: third line dropped
        wr_line(16'h0100);
        wr_line(16'h0200);
        wr_line(16'h0300);
        check("ovf_avail", {30'h0, lines_avail}, 2);
        check("ovf_flag", {31'h0, overflow}, 1);
        read_line(16'h0100);
        read_line(16'h0200);
        check("ovf_avail0", {30'h0, lines_avail}, 0);

        // start-of-frame mid-line
        for (int i = 0; i < 5; i++) wr_pix(16'h0050 + DW'(i), 1'b0);
        wr_pix(16'h00A0, 1'b1);
        for (int i = 1; i < LL; i++) wr_pix(16'h00A0 + DW'(i), 1'b0);
        check("sof_avail", {30'h0, lines_avail}, 1);
        read_line(16'h00A0);

        // commit and release on the same edge
        wr_line(16'h00B0);
        push_line(16'h00B0);
        for (int c = 0; c <= LL; c++) begin
            rd_start = (c == 0);
            wr_en    = (c >= 1);
            wr_data  = 16'h00C0 + DW'(c) - 16'h1;
            tick();
        end
        rd_start = 1'b0; wr_en = 1'b0;
        check("simul_avail", {30'h0, lines_avail}, 1);
        check("simul_busy", {31'h0, rd_busy}, 0);
        wait_idle();
        read_line(16'h00C0);

        // ignored start requests
        pulse_start();
        check("ign_empty_busy", {31'h0, rd_busy}, 0);
        tick(); tick(); tick();
        wr_line(16'h00D0);
        push_line(16'h00D0);
        pulse_start();
        tick(); tick();
        pulse_start();
        check("ign_read_busy", {31'h0, rd_busy}, 1);
        wait_idle();
        tick(); tick(); tick();
        check("ign_avail", {30'h0, lines_avail}, 0);
        check("ign_queue", q.size(), 0);

        // reset on the 4th valid cycle
        check("ovf_sticky", {31'h0, overflow}, 1);
        wr_line(16'h00E0);
        for (int i = 0; i < 4; i++) q.push_back({16'h00E0 + DW'(i), 1'b0});
        pulse_start();
        for (int i = 0; i < 4; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_valid", {31'h0, rd_valid}, 0);
        check("mid_last", {31'h0, rd_last}, 0);
        check("mid_busy", {31'h0, rd_busy}, 0);
        check("mid_avail", {30'h0, lines_avail}, 0);
        check("mid_ovf", {31'h0, overflow}, 0);
        check("mid_data", {16'h0, rd_data}, 0);
        tick(); tick(); tick();
        check("end_queue", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
